// File: rtl/upe_abs_pipe.sv
// upe_abs_pipe: two-stage pipelined absolute-value unit with whole/split lanes,
// wrap/saturate handling of the most-negative input and a saturating
// overflow event counter.

// Single-lane magnitude: two's-complement negate, with most-negative detection
module upe_abs_lane #(
   parameter int L = 16
) (
   input  logic [L-1:0] x,
   input  logic         sat,
   output logic [L-1:0] mag,
   output logic         ovf
);
   localparam logic [L-1:0] MOST_NEG = {1'b1, {(L-1){1'b0}}};
   localparam logic [L-1:0] MAX_POS  = {1'b0, {(L-1){1'b1}}};

   logic [L-1:0] neg;

   // Negate negative inputs; most-negative either wraps (passes through) or clamps
   always_comb begin
      neg = ~x + 1'b1;
      ovf = (x == MOST_NEG);
      mag = x[L-1] ? neg : x;
      if (ovf) mag = sat ? MAX_POS : x;
   end
endmodule

module upe_abs_pipe #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_split,
   input  logic             in_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_sign,
   output logic [1:0]       out_ovf,
   output logic             out_split,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] ovf_cnt
);
   localparam int H      = WIDTH / 2;
   localparam int STAGES = 2;

   // vld_pipe[1] = S1 holds a word, vld_pipe[2] = S2 (output) holds a result
   logic [STAGES:1]    vld_pipe;
   logic               s1_adv, s2_adv;

   logic [WIDTH-1:0]   s1_data;
   logic               s1_split, s1_sat;
   logic [1:0]         s1_sign;

   logic [WIDTH-1:0]   whole_mag;
   logic               whole_ovf;
   logic [1:0][H-1:0]  half_mag;
   logic [1:0]         half_ovf;

   logic [WIDTH-1:0]   res_data;
   logic [1:0]         res_sign, res_ovf;

   logic               out_hs;
   logic [CNT_W:0]     cnt_sum;

   // A stage advances when it is empty or the stage after it is moving
   assign s2_adv    = !vld_pipe[2] | out_ready;
   assign s1_adv    = !vld_pipe[1] | s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = vld_pipe[2];
   assign out_hs    = out_valid & out_ready;

   // Valid bits: each stage takes its predecessor's valid when it advances, else holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else begin
         if (s1_adv) vld_pipe[1] <= in_valid;
         if (s2_adv) vld_pipe[2] <= vld_pipe[1];
      end
   end

   // S1 capture: operand, per-word mode bits and both candidate lane signs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data  <= '0;
         s1_split <= 1'b0;
         s1_sat   <= 1'b0;
         s1_sign  <= '0;
      end else if (s1_adv && in_valid) begin
         s1_data  <= in_data;
         s1_split <= in_split;
         s1_sat   <= in_sat;
         s1_sign  <= {in_data[WIDTH-1], in_data[H-1]};
      end
   end

   // Whole-word lane and two independent half lanes; the mode picks which to keep
   upe_abs_lane #(.L(WIDTH)) u_whole (
      .x   (s1_data),
      .sat (s1_sat),
      .mag (whole_mag),
      .ovf (whole_ovf)
   );

   for (genvar i = 0; i < 2; i++) begin : g_half
      upe_abs_lane #(.L(H)) u_lane (
         .x   (s1_data[i*H +: H]),
         .sat (s1_sat),
         .mag (half_mag[i]),
         .ovf (half_ovf[i])
      );
   end

   // Mode select; lane-1 sign/ovf read as 0 in whole mode
   always_comb begin
      res_data = whole_mag;
      res_sign = {1'b0, s1_sign[1]};
      res_ovf  = {1'b0, whole_ovf};
      if (s1_split) begin
         res_data = half_mag;
         res_sign = s1_sign;
         res_ovf  = half_ovf;
      end
   end

   // S2 result register; holds while stalled so outputs stay stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_sign  <= '0;
         out_ovf   <= '0;
         out_split <= 1'b0;
      end else if (s2_adv && vld_pipe[1]) begin
         out_data  <= res_data;
         out_sign  <= res_sign;
         out_ovf   <= res_ovf;
         out_split <= s1_split;
      end
   end

   // One extra bit catches the carry so the counter can clamp instead of wrapping
   assign cnt_sum = {1'b0, ovf_cnt}
                  + {{CNT_W{1'b0}}, out_ovf[0]}
                  + {{CNT_W{1'b0}}, out_ovf[1]};

   // Overflow counter: clear wins over a same-cycle delivery
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          ovf_cnt <= '0;
      else if (cnt_clr)    ovf_cnt <= '0;
      else if (out_hs)     ovf_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
   end
endmodule

// File: tb/tb_upe_abs_pipe.sv
// Directed bench for upe_abs_pipe (WIDTH=32, CNT_W=16).
module tb_upe_abs_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_split, in_sat;
   logic [31:0] in_data;
   logic        out_valid, out_ready, out_split;
   logic [31:0] out_data;
   logic [1:0]  out_sign, out_ovf;
   logic        cnt_clr;
   logic [15:0] ovf_cnt;

   int checks = 0;
   int errors = 0;

   upe_abs_pipe #(.WIDTH(32), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_split  (in_split),
      .in_sat    (in_sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sign  (out_sign),
      .out_ovf   (out_ovf),
      .out_split (out_split),
      .cnt_clr   (cnt_clr),
      .ovf_cnt   (ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [31:0] d, input logic split, input logic sat);
      in_valid = 1'b1;
      in_data  = d;
      in_split = split;
      in_sat   = sat;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_data  = '0;
      in_split = 1'b0;
      in_sat   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      idle();
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_out_sign",  out_sign,  0);
      chk("rst_out_ovf",   out_ovf,   0);
      chk("rst_out_split", out_split, 0);
      chk("rst_ovf_cnt",   ovf_cnt,   0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      tick();

      // Whole-mode stream, one per cycle, latency 2
      drive(32'h0000_0005, 0, 0); tick();
      chk("w_lat_nv", out_valid, 0);
      drive(32'hFFFF_FFFB, 0, 0); tick();
      chk("w0_valid", out_valid, 1);
      chk("w0_data",  out_data, 32'h5);
      chk("w0_sign",  out_sign, 2'b00);
      drive(32'h7FFF_FFFF, 0, 0); tick();
      chk("w1_valid", out_valid, 1);
      chk("w1_data",  out_data, 32'h5);
      chk("w1_sign",  out_sign, 2'b01);
      idle(); tick();
      chk("w2_valid", out_valid, 1);
      chk("w2_data",  out_data, 32'h7FFF_FFFF);
      chk("w2_sign",  out_sign, 2'b00);
      tick();
      chk("w_drain", out_valid, 0);
      chk("w_cnt",   ovf_cnt, 0);

      // Whole-mode most-negative: wrap then saturate
      drive(32'h8000_0000, 0, 0); tick();
      drive(32'h8000_0000, 0, 1); tick();
      chk("mn_wrap_data", out_data, 32'h8000_0000);
      chk("mn_wrap_ovf",  out_ovf, 2'b01);
      chk("mn_wrap_sign", out_sign, 2'b01);
      idle(); tick();
      chk("mn_sat_data", out_data, 32'h7FFF_FFFF);
      chk("mn_sat_ovf",  out_ovf, 2'b01);
      chk("mn_cnt1",     ovf_cnt, 1);
      tick();
      chk("mn_cnt2", ovf_cnt, 2);

      // Split mode, lanes independent
      drive(32'h8000_FFFF, 1, 1); tick();
      drive(32'h0001_8000, 1, 0); tick();
      chk("sp0_data",  out_data, 32'h7FFF_0001);
      chk("sp0_sign",  out_sign, 2'b11);
      chk("sp0_ovf",   out_ovf, 2'b10);
      chk("sp0_split", out_split, 1);
      idle(); tick();
      chk("sp1_data", out_data, 32'h0001_8000);
      chk("sp1_sign", out_sign, 2'b01);
      chk("sp1_ovf",  out_ovf, 2'b01);
      chk("sp_cnt3",  ovf_cnt, 3);
      tick();
      chk("sp_cnt4", ovf_cnt, 4);

      // Backpressure: four words, downstream stalled
      out_ready = 1'b0;
      drive(32'hFFFF_FFFF, 0, 0); tick();
      chk("bp_rdy_one", in_ready, 1);
      drive(32'h0000_0002, 0, 0); tick();
      chk("bp_rdy_full", in_ready, 0);
      chk("bp_a_valid",  out_valid, 1);
      chk("bp_a_data",   out_data, 32'h1);
      drive(32'hFFFF_FFFD, 0, 0); tick();
      chk("bp_hold1_rdy",  in_ready, 0);
      chk("bp_hold1_data", out_data, 32'h1);
      tick();
      chk("bp_hold2_valid", out_valid, 1);
      chk("bp_hold2_data",  out_data, 32'h1);
      chk("bp_hold2_sign",  out_sign, 2'b01);
      out_ready = 1'b1;
      #1;
      chk("bp_rdy_comb", in_ready, 1);
      tick();
      chk("bp_b_data", out_data, 32'h2);
      drive(32'h1234_5678, 0, 0); tick();
      chk("bp_c_data", out_data, 32'h3);
      idle(); tick();
      chk("bp_d_data", out_data, 32'h1234_5678);
      tick();
      chk("bp_drain", out_valid, 0);
      chk("bp_cnt",   ovf_cnt, 4);

      // Counter: clear, preload to 0xFFFE, clamp, then clear vs increment
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      chk("cnt_clr0", ovf_cnt, 0);
      for (int i = 0; i < 32767; i++) begin
         drive(32'h8000_8000, 1, 0); tick();
      end
      idle(); tick(); tick();
      chk("cnt_pre", ovf_cnt, 16'hFFFE);
      drive(32'h8000_8000, 1, 0); tick();
      idle(); tick();
      chk("cnt_ovf_both", out_ovf, 2'b11);
      tick();
      chk("cnt_clamp", ovf_cnt, 16'hFFFF);
      drive(32'h8000_8000, 1, 1); tick();
      idle(); tick();
      chk("cnt_sat_data", out_data, 32'h7FFF_7FFF);
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      chk("cnt_clr_prio", ovf_cnt, 0);

      // Reset mid-stream with two words in flight
      drive(32'hFFFF_FFF0, 0, 0); tick();
      drive(32'hFFFF_FFE0, 0, 0); tick();
      idle();
      chk("mr_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mr_valid", out_valid, 0);
      chk("mr_data",  out_data, 0);
      rst_n = 1'b1;
      tick();
      chk("mr_stale1", out_valid, 0);
      chk("mr_ready",  in_ready, 1);
      tick();
      chk("mr_stale2", out_valid, 0);
      drive(32'hFFFF_FF00, 0, 0); tick();
      idle();
      chk("mr_lat_nv", out_valid, 0);
      tick();
      chk("mr_lat_valid", out_valid, 1);
      chk("mr_lat_data",  out_data, 32'h100);
      tick();
      chk("mr_drain", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
